// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external memory bus between instruction fetch and the
// MEM-stage load/store path, with MEM priority, a bus timeout and flush-drop.
module mem_bus_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   output logic          if_err,
   input  logic          mem_req,
   input  logic          mem_we,
   input  logic [3:0]    mem_sel,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_wdata,
   output logic [DW-1:0] mem_rdata,
   output logic          mem_ack,
   output logic          mem_err,
   output logic          bus_req,
   output logic          bus_we,
   output logic [3:0]    bus_sel,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic [DW-1:0] bus_rdata,
   input  logic          bus_ack,
   output logic          stall_req_if,
   output logic          stall_req_mem,
   output logic [1:0]    dbg_state
);

   // Handshake: a requester holds *_req and its command stable until it sees
   // the one-cycle *_ack pulse; on the bus, bus_req and the command stay
   // stable until the slave returns a one-cycle bus_ack (or the timer expires).

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_BUSY = 2'd1,
      IF_BUSY  = 2'd2,
      IF_DROP  = 2'd3
   } state_t;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic          bus_req_n, bus_we_n;
   logic [3:0]    bus_sel_n;
   logic [AW-1:0] bus_addr_n;
   logic [DW-1:0] bus_wdata_n, if_rdata_n, mem_rdata_n;
   logic          if_ack_n, if_err_n, mem_ack_n, mem_err_n;

   assign stall_req_if  = if_req & ~if_ack;
   assign stall_req_mem = mem_req & ~mem_ack;
   assign dbg_state     = state;

   always_comb begin
      state_n     = state;
      timer_n     = timer;
      bus_req_n   = bus_req;
      bus_we_n    = bus_we;
      bus_sel_n   = bus_sel;
      bus_addr_n  = bus_addr;
      bus_wdata_n = bus_wdata;
      if_rdata_n  = if_rdata;
      mem_rdata_n = mem_rdata;
      if_ack_n    = 1'b0;
      if_err_n    = 1'b0;
      mem_ack_n   = 1'b0;
      mem_err_n   = 1'b0;

      if (state == IDLE) begin
         timer_n = '0;
         // A requester still seeing its ack this cycle has not yet dropped req.
         if (mem_req && !mem_ack) begin
            bus_req_n   = 1'b1;
            bus_we_n    = mem_we;
            bus_sel_n   = mem_sel;
            bus_addr_n  = mem_addr;
            bus_wdata_n = mem_wdata;
            state_n     = MEM_BUSY;
         end else if (if_req && !if_ack && !flush) begin
            bus_req_n   = 1'b1;
            bus_we_n    = 1'b0;
            bus_sel_n   = 4'hF;
            bus_addr_n  = if_addr;
            bus_wdata_n = '0;
            state_n     = IF_BUSY;
         end
      end else begin
         timer_n = timer + TW'(1);
         if (bus_ack || timer == TIMER_LAST) begin
            bus_req_n = 1'b0;
            timer_n   = '0;
            state_n   = IDLE;
            if (state == MEM_BUSY) begin
               mem_ack_n   = 1'b1;
               mem_err_n   = ~bus_ack;
               mem_rdata_n = (bus_ack && !bus_we) ? bus_rdata : '0;
            end else if (state == IF_BUSY && !flush) begin
               if_ack_n   = 1'b1;
               if_err_n   = ~bus_ack;
               if_rdata_n = bus_ack ? bus_rdata : '0;
            end
         end else if (state == IF_BUSY && flush) begin
            // The issued bus cycle must still complete; only its result dies.
            state_n = IF_DROP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_sel   <= 4'h0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
         if_ack    <= 1'b0;
         if_err    <= 1'b0;
         mem_ack   <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         bus_req   <= bus_req_n;
         bus_we    <= bus_we_n;
         bus_sel   <= bus_sel_n;
         bus_addr  <= bus_addr_n;
         bus_wdata <= bus_wdata_n;
         if_rdata  <= if_rdata_n;
         mem_rdata <= mem_rdata_n;
         if_ack    <= if_ack_n;
         if_err    <= if_err_n;
         mem_ack   <= mem_ack_n;
         mem_err   <= mem_err_n;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a short
// randomised run, with expected responses held in per-requester queues.
module tb_mem_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ack, if_err;
   logic          mem_req, mem_we;
   logic [3:0]    mem_sel;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_ack, mem_err;
   logic          bus_req, bus_we;
   logic [3:0]    bus_sel;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata, bus_rdata;
   logic          bus_ack;
   logic          stall_req_if, stall_req_mem;
   logic [1:0]    dbg_state;

   int total = 0;
   int bad   = 0;

   // Expected {err, rdata} per completion, pushed when stimulus is driven.
   logic [DW:0] exp_if_q[$];
   logic [DW:0] exp_mem_q[$];
   logic [DW:0] exp;

   mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ack(if_ack), .if_err(if_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .mem_err(mem_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ack(bus_ack), .stall_req_if(stall_req_if),
      .stall_req_mem(stall_req_mem), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled and inputs driven 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_fetch(input logic [AW-1:0] a);
      if_req  = 1'b1;
      if_addr = a;
   endtask

   task automatic drive_mem(input logic we, input logic [3:0] sel,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
      mem_req   = 1'b1;
      mem_we    = we;
      mem_sel   = sel;
      mem_addr  = a;
      mem_wdata = d;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = '0;
      mem_wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      total++;
      if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata} !== '0) begin
         bad++;
         $display("FAIL reset_bus: got req=%b we=%b sel=%h addr=%h wdata=%h, want all 0",
                  bus_req, bus_we, bus_sel, bus_addr, bus_wdata);
      end
      total++;
      if ({if_ack, if_err, mem_ack, mem_err, if_rdata, mem_rdata, dbg_state} !== '0) begin
         bad++;
         $display("FAIL reset_resp: got acks=%b%b errs=%b%b rdata=%h/%h state=%0d, want 0",
                  if_ack, mem_ack, if_err, mem_err, if_rdata, mem_rdata, dbg_state);
      end
   endtask

   task automatic test_fetch();
      drive_fetch(32'h100);
      exp_if_q.push_back({1'b0, 32'h0000_0013});
      tick();
      total++;
      if ({bus_req, bus_we, bus_sel, bus_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
         bad++;
         $display("FAIL fetch_cmd: got req=%b we=%b sel=%h addr=%h, want 1 0 f 00000100",
                  bus_req, bus_we, bus_sel, bus_addr);
      end
      total++;
      if (stall_req_if !== 1'b1) begin
         bad++;
         $display("FAIL fetch_stall_busy: got %b want 1", stall_req_if);
      end
      bus_ack = 1'b1; bus_rdata = 32'h13;
      tick();
      bus_ack = 1'b0;
      total++;
      if (if_ack !== 1'b1 || exp_if_q.size() == 0) begin
         bad++;
         $display("FAIL fetch_ack: got if_ack=%b want 1", if_ack);
      end else begin
         exp = exp_if_q.pop_front();
         if ({if_err, if_rdata} !== exp) begin
            bad++;
            $display("FAIL fetch_data: got err=%b rdata=%h want %h", if_err, if_rdata, exp);
         end
      end
      total++;
      if (stall_req_if !== 1'b0 || bus_req !== 1'b0) begin
         bad++;
         $display("FAIL fetch_release: got stall=%b bus_req=%b want 0 0", stall_req_if, bus_req);
      end
      if_req = 1'b0;
      tick();
      total++;
      if (if_ack !== 1'b0) begin
         bad++;
         $display("FAIL fetch_pulse: got if_ack=%b want 0", if_ack);
      end
   endtask

   task automatic test_priority();
      logic [DW-1:0] d0, d1;
      d0 = $urandom(); d1 = $urandom();
      drive_fetch(32'h400);
      drive_mem(1'b0, 4'hF, 32'h2000, '0);
      exp_mem_q.push_back({1'b0, d0});
      exp_if_q.push_back({1'b0, d1});
      tick();
      total++;
      if (bus_addr !== 32'h2000 || bus_we !== 1'b0 || dbg_state !== 2'd1) begin
         bad++;
         $display("FAIL prio_first: got addr=%h we=%b state=%0d want 00002000 0 1",
                  bus_addr, bus_we, dbg_state);
      end
      total++;
      if (stall_req_if !== 1'b1 || stall_req_mem !== 1'b1) begin
         bad++;
         $display("FAIL prio_stalls: got if=%b mem=%b want 1 1", stall_req_if, stall_req_mem);
      end
      bus_ack = 1'b1; bus_rdata = d0;
      tick();
      bus_ack = 1'b0;
      total++;
      if (mem_ack !== 1'b1 || bus_req !== 1'b0 || exp_mem_q.size() == 0) begin
         bad++;
         $display("FAIL prio_mem_ack: got mem_ack=%b bus_req=%b want 1 0", mem_ack, bus_req);
      end else begin
         exp = exp_mem_q.pop_front();
         if ({mem_err, mem_rdata} !== exp) begin
            bad++;
            $display("FAIL prio_mem_data: got %b/%h want %h", mem_err, mem_rdata, exp);
         end
      end
      mem_req = 1'b0;
      tick();
      total++;
      if (bus_req !== 1'b1 || bus_addr !== 32'h400 || bus_sel !== 4'hF) begin
         bad++;
         $display("FAIL prio_fetch_issue: got req=%b addr=%h sel=%h want 1 00000400 f",
                  bus_req, bus_addr, bus_sel);
      end
      bus_ack = 1'b1; bus_rdata = d1;
      tick();
      bus_ack = 1'b0;
      total++;
      if (if_ack !== 1'b1 || exp_if_q.size() == 0) begin
         bad++;
         $display("FAIL prio_if_ack: got if_ack=%b want 1", if_ack);
      end else begin
         exp = exp_if_q.pop_front();
         if ({if_err, if_rdata} !== exp) begin
            bad++;
            $display("FAIL prio_if_data: got %b/%h want %h", if_err, if_rdata, exp);
         end
      end
      if_req = 1'b0;
      tick();
   endtask

   task automatic test_flush_drop();
      int acks;
      drive_fetch(32'h104);
      tick();
      flush = 1'b1; if_req = 1'b0;
      tick();
      flush = 1'b0;
      total++;
      if (dbg_state !== 2'd3 || bus_req !== 1'b1 || bus_addr !== 32'h104) begin
         bad++;
         $display("FAIL flush_drop_state: got state=%0d req=%b addr=%h want 3 1 00000104",
                  dbg_state, bus_req, bus_addr);
      end
      acks = 0;
      tick();
      if (if_ack) acks++;
      bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      tick();
      bus_ack = 1'b0;
      if (if_ack) acks++;
      tick();
      if (if_ack) acks++;
      total++;
      if (acks != 0 || bus_req !== 1'b0 || dbg_state !== 2'd0) begin
         bad++;
         $display("FAIL flush_silent: got acks=%0d req=%b state=%0d want 0 0 0",
                  acks, bus_req, dbg_state);
      end
      drive_fetch(32'h200);
      exp_if_q.push_back({1'b0, 32'h0000_0A5A});
      tick();
      total++;
      if (bus_req !== 1'b1 || bus_addr !== 32'h200) begin
         bad++;
         $display("FAIL flush_next_issue: got req=%b addr=%h want 1 00000200", bus_req, bus_addr);
      end
      bus_ack = 1'b1; bus_rdata = 32'h0A5A;
      tick();
      bus_ack = 1'b0;
      total++;
      if (if_ack !== 1'b1 || exp_if_q.size() == 0) begin
         bad++;
         $display("FAIL flush_next_ack: got if_ack=%b want 1", if_ack);
      end else begin
         exp = exp_if_q.pop_front();
         if ({if_err, if_rdata} !== exp) begin
            bad++;
            $display("FAIL flush_next_data: got %b/%h want %h", if_err, if_rdata, exp);
         end
      end
      if_req = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int high;
      drive_mem(1'b1, 4'hF, 32'h3000, $urandom());
      exp_mem_q.push_back({1'b1, 32'h0});
      tick();
      high = 0;
      for (int i = 0; i < 12; i++) begin
         if (mem_ack) break;
         if (bus_req) high++;
         tick();
      end
      total++;
      if (high != 4) begin
         bad++;
         $display("FAIL timeout_len: got bus_req high %0d cycles want 4", high);
      end
      total++;
      if (mem_ack !== 1'b1 || bus_req !== 1'b0 || exp_mem_q.size() == 0) begin
         bad++;
         $display("FAIL timeout_ack: got mem_ack=%b bus_req=%b want 1 0", mem_ack, bus_req);
      end else begin
         exp = exp_mem_q.pop_front();
         if ({mem_err, mem_rdata} !== exp) begin
            bad++;
            $display("FAIL timeout_err: got %b/%h want %h", mem_err, mem_rdata, exp);
         end
      end
      mem_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      int acks;
      drive_mem(1'b0, 4'hF, 32'h5000, '0);
      tick();
      rst = 1'b1; mem_req = 1'b0;
      tick();
      rst = 1'b0;
      total++;
      if (bus_req !== 1'b0 || dbg_state !== 2'd0) begin
         bad++;
         $display("FAIL rst_mid: got bus_req=%b state=%0d want 0 0", bus_req, dbg_state);
      end
      acks = mem_ack ? 1 : 0;
      bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
      tick();
      bus_ack = 1'b0;
      if (mem_ack) acks++;
      tick();
      if (mem_ack) acks++;
      total++;
      if (acks != 0 || bus_req !== 1'b0 || dbg_state !== 2'd0) begin
         bad++;
         $display("FAIL rst_late_ack: got acks=%0d req=%b state=%0d want 0 0 0",
                  acks, bus_req, dbg_state);
      end
   endtask

   task automatic test_store();
      drive_mem(1'b1, 4'b0011, 32'h6000, 32'hAABB_CCDD);
      exp_mem_q.push_back({1'b0, 32'h0});
      tick();
      mem_wdata = 32'h0;  // the latched command must not track the requester
      for (int i = 0; i < 2; i++) begin
         total++;
         if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata} !==
             {1'b1, 1'b1, 4'b0011, 32'h6000, 32'hAABB_CCDD}) begin
            bad++;
            $display("FAIL store_cmd_%0d: got req=%b we=%b sel=%b addr=%h wdata=%h", i,
                     bus_req, bus_we, bus_sel, bus_addr, bus_wdata);
         end
         if (i == 1) begin
            bus_ack = 1'b1; bus_rdata = 32'hFFFF_0001;
         end
         tick();
      end
      bus_ack = 1'b0;
      total++;
      if (mem_ack !== 1'b1 || exp_mem_q.size() == 0) begin
         bad++;
         $display("FAIL store_ack: got mem_ack=%b want 1", mem_ack);
      end else begin
         exp = exp_mem_q.pop_front();
         if ({mem_err, mem_rdata} !== exp) begin
            bad++;
            $display("FAIL store_rdata: got %b/%h want %h", mem_err, mem_rdata, exp);
         end
      end
      mem_req = 1'b0;
      tick();
   endtask

   task automatic test_random();
      int kind, dly, waited;
      logic [DW-1:0] d;
      logic [AW-1:0] a;
      logic got_ack;
      for (int n = 0; n < 10; n++) begin
         kind = $urandom_range(0, 3);  // 0 fetch, 1 load, 2 store, 3 fetch timeout
         dly  = $urandom_range(0, 2);
         d    = $urandom();
         a    = {$urandom_range(0, 16'hFFFF), 2'b00};
         if (kind == 0 || kind == 3) begin
            drive_fetch(a);
            exp_if_q.push_back(kind == 3 ? {1'b1, 32'h0} : {1'b0, d});
         end else begin
            drive_mem(kind == 2, 4'hF, a, d);
            exp_mem_q.push_back(kind == 2 ? {1'b0, 32'h0} : {1'b0, d});
         end
         tick();
         total++;
         if (bus_req !== 1'b1 || bus_addr !== a || bus_we !== (kind == 2)) begin
            bad++;
            $display("FAIL rand_issue_%0d: got req=%b addr=%h we=%b want 1 %h %b",
                     n, bus_req, bus_addr, bus_we, a, kind == 2);
         end
         if (kind != 3) begin
            repeat (dly) tick();
            bus_ack = 1'b1; bus_rdata = d;
         end
         got_ack = 1'b0;
         waited  = 0;
         while (!got_ack && waited < 10) begin
            tick();
            bus_ack = 1'b0;
            got_ack = (kind == 0 || kind == 3) ? if_ack : mem_ack;
            waited++;
         end
         total++;
         if (!got_ack) begin
            bad++;
            $display("FAIL rand_ack_%0d: got no ack within 10 cycles, want ack", n);
         end else if (kind == 0 || kind == 3) begin
            exp = exp_if_q.pop_front();
            if ({if_err, if_rdata} !== exp) begin
               bad++;
               $display("FAIL rand_if_%0d: got %b/%h want %h", n, if_err, if_rdata, exp);
            end
         end else begin
            exp = exp_mem_q.pop_front();
            if ({mem_err, mem_rdata} !== exp) begin
               bad++;
               $display("FAIL rand_mem_%0d: got %b/%h want %h", n, mem_err, mem_rdata, exp);
            end
         end
         if_req = 1'b0; mem_req = 1'b0;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_flush_drop();
      test_timeout();
      test_reset_mid();
      test_store();
      test_random();
      total++;
      if (exp_if_q.size() != 0 || exp_mem_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_expect: got %0d/%0d queued want 0/0",
                  exp_if_q.size(), exp_mem_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
